rgb_gray_stream_converter: RTL and testbench

- Downstream neighbour of the OV7670 capture stream core, on the same pixel clock.
- Consumes its 32-bit AXI4-Stream RGB video (TUSER = start of frame, TLAST = end of line).
- Converts each pixel to 8-bit luma through a 2-stage pipeline with valid/ready backpressure.
- Validates frame geometry, regenerates clean SOF/EOL sideband for the analysis path, and reports status counters.

---
 rtl/video_stream_pkg.sv | 23 ++
 rtl/rgb_gray_stream_converter_if.sv | 16 +
 rtl/luma_pipe.sv | 78 +++++++
 rtl/rgb_gray_stream_converter.sv | 181 ++++++++++++++++++
 tb/tb_rgb_gray_stream_converter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/video_stream_pkg.sv
// Shared video-stream definitions for the RGB-to-luma path.
// Holds default frame geometry, RGB32 byte-lane offsets, default luma weights (Q0.8, summing to
// 256) and the frame-tracking FSM state encoding.
package video_stream_pkg;

  localparam int unsigned HActiveDefault = 640;
  localparam int unsigned VActiveDefault = 480;

  // Byte-lane offsets inside a 32-bit RGB beat; bits [31:24] carry no colour.
  localparam int unsigned RLsb = 0;
  localparam int unsigned GLsb = 8;
  localparam int unsigned BLsb = 16;

  localparam int unsigned CoefRDefault = 77;
  localparam int unsigned CoefGDefault = 150;
  localparam int unsigned CoefBDefault = 29;

  typedef enum logic [0:0] {
    StWaitSof,
    StInFrame
  } frame_state_e;

endpackage

// File: rtl/rgb_gray_stream_converter_if.sv
// AXI4-Stream video bundle.
// tdata/tvalid/tuser(SOF)/tlast(EOL) flow master -> slave, tready flows slave -> master.
interface rgb_gray_stream_converter_if #(
  parameter int unsigned DataWidth = 32
) ();

  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tuser;
  logic                 tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/luma_pipe.sv
// Two-stage luma datapath: stage 1 registers the three weighted products, stage 2 registers
// Y = (R*CR + G*CG + B*CB) >> 8. Both stages move together on 'advance'; sideband flags
// (SOF, EOL, end-of-frame) ride alongside the data.
// Ports: pclk/aresetn; advance (global enable); in_* pixel and flags; out_* luma and flags.
module luma_pipe #(
  parameter int unsigned COEF_R = 77,
  parameter int unsigned COEF_G = 150,
  parameter int unsigned COEF_B = 29
) (
  input  logic       pclk,
  input  logic       aresetn,
  input  logic       advance,
  input  logic       in_valid,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_sof,
  input  logic       in_eol,
  input  logic       in_eof,
  output logic       out_valid,
  output logic [7:0] out_y,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof
);

  logic [15:0] prod_r_d, prod_g_d, prod_b_d;
  logic [15:0] prod_r_q, prod_g_q, prod_b_q;
  logic        s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
  logic [15:0] sum;
  logic [7:0]  y_q;
  logic        s2_valid_q, s2_sof_q, s2_eol_q, s2_eof_q;

  always_comb begin
    prod_r_d = 16'(in_r) * 16'(COEF_R);
    prod_g_d = 16'(in_g) * 16'(COEF_G);
    prod_b_d = 16'(in_b) * 16'(COEF_B);
    // Weights sum to 256, so the worst case is 255*256 = 65280: no carry out of 16 bits.
    sum      = prod_r_q + prod_g_q + prod_b_q;
  end

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      prod_r_q   <= '0;
      prod_g_q   <= '0;
      prod_b_q   <= '0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      s2_sof_q   <= 1'b0;
      s2_eol_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      prod_r_q   <= prod_r_d;
      prod_g_q   <= prod_g_d;
      prod_b_q   <= prod_b_d;
      s1_sof_q   <= in_sof;
      s1_eol_q   <= in_eol;
      s1_eof_q   <= in_eof;
      s2_valid_q <= s1_valid_q;
      y_q        <= 8'(sum >> 8);
      s2_sof_q   <= s1_sof_q;
      s2_eol_q   <= s1_eol_q;
      s2_eof_q   <= s1_eof_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = y_q;
  assign out_sof   = s2_sof_q;
  assign out_eol   = s2_eol_q;
  assign out_eof   = s2_eof_q;

endmodule

// File: rtl/rgb_gray_stream_converter.sv
// RGB32 AXI4-Stream to 8-bit luma converter with frame-geometry checking.
// Tracks x/y of every accepted pixel, regenerates SOF/EOL from those counters, flags
// unexpected SOF / bad EOL as sticky errors, and counts frames and overflow-dropped beats.
// Ports:
//   pclk, aresetn          clock, asynchronous active-low reset
//   s_axis (slave)         RGB input: tdata[7:0]=R [15:8]=G [23:16]=B, tuser=SOF, tlast=EOL
//   m_axis (master)        luma output: tdata=Y, tuser=SOF, tlast=EOL
//   stat_clr               synchronous clear of counters and sticky errors
//   frame_count            completed frames (wrapping)
//   drop_count             beats lost while stalled (saturating)
//   err_sof, err_eol       sticky geometry errors
//   frame_done             one-cycle pulse after the last pixel of a frame leaves
module rgb_gray_stream_converter
  import video_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDefault,
  parameter int unsigned V_ACTIVE = VActiveDefault,
  parameter int unsigned COEF_R   = CoefRDefault,
  parameter int unsigned COEF_G   = CoefGDefault,
  parameter int unsigned COEF_B   = CoefBDefault
) (
  input  logic                              pclk,
  input  logic                              aresetn,
  rgb_gray_stream_converter_if.slave        s_axis,
  rgb_gray_stream_converter_if.master       m_axis,
  input  logic                              stat_clr,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       drop_count,
  output logic                              err_sof,
  output logic                              err_eol,
  output logic                              frame_done
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  // One spare code so an early EOL on the last line cannot alias back to line 0.
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLast = YW'(V_ACTIVE - 1);

  frame_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, bx;
  logic [YW-1:0] y_q, y_d, by;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          err_sof_q, err_sof_d, err_eol_q, err_eol_d;
  logic          frame_done_q, frame_done_d;

  logic advance, accept, drop;
  logic pix_valid, pix_sof, pix_eol, pix_eof;
  logic out_valid, out_sof, out_eol, out_eof;
  logic [7:0] out_y;
  logic unused_alpha;

  assign unused_alpha = ^s_axis.tdata[31:24];

  assign advance       = !out_valid || m_axis.tready;
  assign s_axis.tready = advance;
  assign accept        = s_axis.tvalid && advance;
  // The source ignores tready, so any refused beat is gone for good.
  assign drop          = s_axis.tvalid && !advance;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    bx            = x_q;
    by            = y_q;
    pix_valid     = 1'b0;
    pix_sof       = 1'b0;
    pix_eol       = 1'b0;
    pix_eof       = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    err_sof_d     = err_sof_q;
    err_eol_d     = err_eol_q;
    frame_done_d  = out_valid && m_axis.tready && out_eof;

    // In StWaitSof non-SOF beats are accepted and discarded without counting as drops.
    if (accept && (state_q == StInFrame || s_axis.tuser)) begin
      pix_valid = 1'b1;
      if (s_axis.tuser) begin
        if (state_q == StInFrame && (x_q != '0 || y_q != '0)) begin
          err_sof_d = 1'b1;
        end
        bx      = '0;
        by      = '0;
        state_d = StInFrame;
      end
      pix_sof = (bx == '0) && (by == '0);
      pix_eol = (bx == XLast);
      if (bx == XLast) begin
        if (!s_axis.tlast) begin
          err_eol_d = 1'b1;
        end
        x_d = '0;
        if (by == YLast) begin
          pix_eof       = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StWaitSof;
          y_d           = '0;
        end else begin
          y_d = by + YW'(1);
        end
      end else if (s_axis.tlast) begin
        err_eol_d = 1'b1;
        x_d       = '0;
        y_d       = by + YW'(1);
      end else begin
        x_d = bx + XW'(1);
        y_d = by;
      end
    end

    if (drop && drop_count_q != 16'hFFFF) begin
      drop_count_d = drop_count_q + 16'd1;
    end

    if (stat_clr) begin
      frame_count_d = '0;
      drop_count_d  = '0;
      err_sof_d     = 1'b0;
      err_eol_d     = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StWaitSof;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      err_sof_q     <= 1'b0;
      err_eol_q     <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      err_sof_q     <= err_sof_d;
      err_eol_q     <= err_eol_d;
      frame_done_q  <= frame_done_d;
    end
  end

  luma_pipe #(
    .COEF_R (COEF_R),
    .COEF_G (COEF_G),
    .COEF_B (COEF_B)
  ) u_luma_pipe (
    .pclk      (pclk),
    .aresetn   (aresetn),
    .advance   (advance),
    .in_valid  (pix_valid),
    .in_r      (s_axis.tdata[RLsb +: 8]),
    .in_g      (s_axis.tdata[GLsb +: 8]),
    .in_b      (s_axis.tdata[BLsb +: 8]),
    .in_sof    (pix_sof),
    .in_eol    (pix_eol),
    .in_eof    (pix_eof),
    .out_valid (out_valid),
    .out_y     (out_y),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_y;
  assign m_axis.tuser  = out_sof;
  assign m_axis.tlast  = out_eol;

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign err_sof     = err_sof_q;
  assign err_eol     = err_eol_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_rgb_gray_stream_converter.sv
// Scoreboard bench for rgb_gray_stream_converter with a reduced 16x4 frame.
module tb_rgb_gray_stream_converter;

  localparam int unsigned H = 16;
  localparam int unsigned V = 4;

  logic        pclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        stat_clr = 1'b0;
  logic [15:0] frame_count, drop_count;
  logic        err_sof, err_eol, frame_done;

  rgb_gray_stream_converter_if #(.DataWidth(32)) s_if ();
  rgb_gray_stream_converter_if #(.DataWidth(8))  m_if ();

  always #5 pclk = ~pclk;

  rgb_gray_stream_converter #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .pclk        (pclk),
    .aresetn     (aresetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .stat_clr    (stat_clr),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .err_sof     (err_sof),
    .err_eol     (err_eol),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] y, input logic sof, input logic eol);
    exp_t e;
    e.y = y;
    e.sof = sof;
    e.eol = eol;
    q.push_back(e);
  endtask

  task automatic beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic u, input logic l);
    s_if.tdata  = {8'h5A, b, g, r};
    s_if.tvalid = 1'b1;
    s_if.tuser  = u;
    s_if.tlast  = l;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge pclk);
      n++;
    end
    #1;
    check(name, q.size(), 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge pclk);
      if (aresetn) begin
        if (frame_done) fd_cnt++;
        if (m_if.tvalid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got y=%0d, expected no output", m_if.tdata);
          end else begin
            check("m_tdata", int'(m_if.tdata), int'(q[0].y));
            check("m_tuser", int'(m_if.tuser), int'(q[0].sof));
            check("m_tlast", int'(m_if.tlast), int'(q[0].eol));
            if (m_if.tready) void'(q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    s_if.tdata  = '0;
    idle();
    m_if.tready = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_s_tready", s_if.tready, 1);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_err_eol", err_eol, 0);
    check("rst_frame_done", frame_done, 0);
    aresetn = 1'b1;
    step(2);

    // White SOF, then single-channel pixels.
    push(8'd255, 1'b1, 1'b0); beat(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    push(8'd76,  1'b0, 1'b0); beat(8'd255, 8'd0,   8'd0,   1'b0, 1'b0);
    push(8'd149, 1'b0, 1'b0); beat(8'd0,   8'd255, 8'd0,   1'b0, 1'b0);
    push(8'd28,  1'b0, 1'b0); beat(8'd0,   8'd0,   8'd255, 1'b0, 1'b0);
    idle();
    drain("drain_colors");

    // Reset with a beat in flight: it must never appear.
    beat(8'd10, 8'd10, 8'd10, 1'b0, 1'b0);
    idle();
    aresetn = 1'b0;
    step(1);
    check("flush_m_tvalid", m_if.tvalid, 0);
    step(1);
    aresetn = 1'b1;
    step(4);
    check("flush_after_release", m_if.tvalid, 0);

    // No SOF yet: beats are swallowed silently.
    for (int i = 0; i < 10; i++) beat(8'(i * 10), 8'd0, 8'd0, 1'b0, 1'b0);
    idle();
    step(4);
    check("nosof_drop_count", drop_count, 0);
    check("nosof_m_tvalid", m_if.tvalid, 0);

    // Full frame of gray pixels: gray level g gives Y == g.
    fd_cnt = 0;
    for (int i = 0; i < int'(H * V); i++) begin
      logic [7:0] g;
      logic       u, l;
      g = 8'(i);
      u = (i == 0);
      l = ((i % int'(H)) == int'(H) - 1);
      push(g, u, l);
      beat(g, g, g, u, l);
    end
    idle();
    drain("drain_frame");
    step(3);
    check("frame_done_pulses", fd_cnt, 1);
    check("frame_count_1", frame_count, 1);
    check("frame_drop_count", drop_count, 0);
    check("frame_err_sof", err_sof, 0);
    check("frame_err_eol", err_eol, 0);

    // Back in wait-for-SOF after the frame.
    beat(8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
    idle();
    step(4);
    check("post_frame_m_tvalid", m_if.tvalid, 0);

    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    check("clr_frame_count", frame_count, 0);

    // Stall 5 cycles from an empty pipe: two beats absorbed, three lost.
    m_if.tready = 1'b0;
    push(8'd200, 1'b1, 1'b0); beat(8'd200, 8'd200, 8'd200, 1'b1, 1'b0);
    push(8'd201, 1'b0, 1'b0); beat(8'd201, 8'd201, 8'd201, 1'b0, 1'b0);
    check("s_tready_stall", s_if.tready, 0);
    beat(8'd202, 8'd202, 8'd202, 1'b0, 1'b0);
    beat(8'd203, 8'd203, 8'd203, 1'b0, 1'b0);
    beat(8'd204, 8'd204, 8'd204, 1'b0, 1'b0);
    idle();
    check("stall_drop_count", drop_count, 3);
    check("stall_m_tvalid", m_if.tvalid, 1);
    m_if.tready = 1'b1;
    drain("drain_stall");

    // Resume at x=2, then early TLAST at x=5.
    push(8'd50, 1'b0, 1'b0); beat(8'd50, 8'd50, 8'd50, 1'b0, 1'b0);
    push(8'd60, 1'b0, 1'b0); beat(8'd60, 8'd60, 8'd60, 1'b0, 1'b0);
    push(8'd61, 1'b0, 1'b0); beat(8'd61, 8'd61, 8'd61, 1'b0, 1'b0);
    push(8'd62, 1'b0, 1'b0); beat(8'd62, 8'd62, 8'd62, 1'b0, 1'b1);
    idle();
    step(1);
    check("early_eol_err_eol", err_eol, 1);
    check("early_eol_err_sof", err_sof, 0);

    // Next line: SOF arrives at x=5 and restarts geometry.
    for (int x = 0; x < 5; x++) begin
      push(8'(70 + x), 1'b0, 1'b0);
      beat(8'(70 + x), 8'(70 + x), 8'(70 + x), 1'b0, 1'b0);
    end
    push(8'd90, 1'b1, 1'b0); beat(8'd90, 8'd90, 8'd90, 1'b1, 1'b0);
    for (int k = 1; k < int'(H); k++) begin
      push(8'(100 + k), 1'b0, k == int'(H) - 1);
      beat(8'(100 + k), 8'(100 + k), 8'(100 + k), 1'b0, k == int'(H) - 1);
    end
    idle();
    drain("drain_resync");
    check("resync_err_sof", err_sof, 1);
    check("resync_err_eol", err_eol, 1);
    check("resync_drop_count", drop_count, 3);

    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    check("clr_err_sof", err_sof, 0);
    check("clr_err_eol", err_eol, 0);
    check("clr_drop_count", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
